// File: rtl/pickup_spawn_scheduler_pkg.sv
// Shared types and defaults for the pickup spawn scheduler.
package pickup_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GAP,
    ST_WAIT_RAND,
    ST_CHECK_MAP,
    ST_PLACE
  } state_t;

  typedef logic [4:0] tile_x_t;
  typedef logic [3:0] tile_y_t;

  localparam int GRID_W_DEF = 20;
  localparam int GRID_H_DEF = 15;

endpackage

// File: rtl/pickup_spawn_scheduler_if.sv
// Tile-map lookup handshake: the scheduler asks whether a tile is occupied.
interface pickup_spawn_scheduler_if;
  import pickup_pkg::*;

  logic    map_req;
  tile_x_t map_x;
  tile_y_t map_y;
  logic    map_ack;
  logic    map_occupied;

  modport master (output map_req, map_x, map_y, input map_ack, map_occupied);
  modport slave  (input map_req, map_x, map_y, output map_ack, map_occupied);

endinterface

// File: rtl/pickup_spawn_scheduler_slot.sv
// One pickup slot: tile position, live flag and lifetime counter.
module pickup_slot
  import pickup_pkg::*;
#(
  parameter int LIFETIME_SEC = 15
) (
  input  logic    clk,
  input  logic    resetN,
  input  logic    one_sec,
  input  logic    load,
  input  logic    hit,
  input  tile_x_t tile_x_in,
  input  tile_y_t tile_y_in,
  output logic    active,
  output tile_x_t tile_x,
  output tile_y_t tile_y
);

  localparam int LIFE_W = (LIFETIME_SEC > 0) ? $clog2(LIFETIME_SEC + 1) : 1;

  logic [LIFE_W-1:0] life;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      active <= 1'b0;
      life   <= '0;
      tile_x <= '0;
      tile_y <= '0;
    end else if (load) begin
      active <= 1'b1;
      life   <= '0;
      tile_x <= tile_x_in;
      tile_y <= tile_y_in;
    end else if (active) begin
      // tile registers keep their last value after the slot retires
      if (hit || life == LIFE_W'(LIFETIME_SEC)) begin
        active <= 1'b0;
        life   <= '0;
      end else if (one_sec) begin
        life <= life + 1'b1;
      end
    end
  end

endmodule

// File: rtl/pickup_spawn_scheduler.sv
// Bonus-pickup spawn scheduler: picks random tiles, validates them and fills free slots.
//   state      | meaning
//   IDLE       | game stopped, nothing scheduled
//   GAP        | counting one_sec pulses between spawn attempts
//   WAIT_RAND  | waiting for a random candidate tile, rejecting bad ones
//   CHECK_MAP  | tile-map lookup in flight
//   PLACE      | loading the lowest free slot
module pickup_spawn_scheduler
  import pickup_pkg::*;
#(
  parameter int NUM_SLOTS     = 4,
  parameter int SPAWN_GAP_SEC = 5,
  parameter int LIFETIME_SEC  = 15,
  parameter int MAX_RETRY     = 7,
  parameter int GRID_W        = GRID_W_DEF,
  parameter int GRID_H        = GRID_H_DEF
) (
  input  logic                     clk,
  input  logic                     resetN,
  input  logic                     one_sec,
  input  logic                     enable,
  input  logic                     rand_valid,
  input  tile_x_t                  rand_x,
  input  tile_y_t                  rand_y,
  pickup_spawn_scheduler_if.master map,
  input  logic [NUM_SLOTS-1:0]     slot_hit,
  output logic [NUM_SLOTS-1:0]     slot_active,
  output tile_x_t [NUM_SLOTS-1:0]  slot_tile_x,
  output tile_y_t [NUM_SLOTS-1:0]  slot_tile_y,
  output logic                     spawn_pulse,
  output logic                     spawn_fail
);

  localparam int GAP_W   = (SPAWN_GAP_SEC > 0) ? $clog2(SPAWN_GAP_SEC + 1) : 1;
  localparam int RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  state_t               state;
  logic [GAP_W-1:0]     gap;
  logic [RETRY_W-1:0]   retry;
  tile_x_t              cand_x;
  tile_y_t              cand_y;
  logic                 map_req_r;
  logic                 dup;
  logic                 cand_bad;
  logic                 at_limit;
  logic                 any_free;
  logic [NUM_SLOTS-1:0] free_onehot;
  logic [NUM_SLOTS-1:0] load_vec;

  assign map.map_req = map_req_r;
  assign map.map_x   = cand_x;
  assign map.map_y   = cand_y;

  always_comb begin
    dup = 1'b0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (slot_active[i] && slot_tile_x[i] == rand_x && slot_tile_y[i] == rand_y)
        dup = 1'b1;
    end
  end

  assign cand_bad = ({1'b0, rand_x} >= 6'(GRID_W)) ||
                    ({1'b0, rand_y} >= 5'(GRID_H)) || dup;
  assign at_limit = (retry == RETRY_W'(MAX_RETRY));

  // Uses the registered active flags, so a slot retiring this cycle is not yet free.
  always_comb begin
    free_onehot = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (!slot_active[i] && free_onehot == '0)
        free_onehot[i] = 1'b1;
    end
  end

  assign any_free = ~&slot_active;
  assign load_vec = (state == ST_PLACE && enable) ? free_onehot : '0;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state       <= ST_IDLE;
      gap         <= '0;
      retry       <= '0;
      cand_x      <= '0;
      cand_y      <= '0;
      map_req_r   <= 1'b0;
      spawn_pulse <= 1'b0;
      spawn_fail  <= 1'b0;
    end else begin
      spawn_pulse <= 1'b0;
      spawn_fail  <= 1'b0;
      if (!enable && state != ST_CHECK_MAP) begin
        state <= ST_IDLE;
        gap   <= '0;
        retry <= '0;
      end else begin
        case (state)
          ST_IDLE: state <= ST_GAP;
          ST_GAP: begin
            if (gap == GAP_W'(SPAWN_GAP_SEC)) begin
              gap   <= '0;
              state <= ST_WAIT_RAND;
            end else if (one_sec && any_free) begin
              gap <= gap + 1'b1;
            end
          end
          ST_WAIT_RAND: begin
            if (rand_valid) begin
              cand_x <= rand_x;
              cand_y <= rand_y;
              if (!cand_bad) begin
                map_req_r <= 1'b1;
                state     <= ST_CHECK_MAP;
              end else if (at_limit) begin
                spawn_fail <= 1'b1;
                retry      <= '0;
                state      <= ST_GAP;
              end else begin
                retry <= retry + 1'b1;
              end
            end
          end
          ST_CHECK_MAP: begin
            // the lookup handshake always completes, even when the game stops
            if (map.map_ack) begin
              map_req_r <= 1'b0;
              if (!enable) begin
                gap   <= '0;
                retry <= '0;
                state <= ST_IDLE;
              end else if (!map.map_occupied) begin
                state <= ST_PLACE;
              end else if (at_limit) begin
                spawn_fail <= 1'b1;
                retry      <= '0;
                state      <= ST_GAP;
              end else begin
                retry <= retry + 1'b1;
                state <= ST_WAIT_RAND;
              end
            end
          end
          ST_PLACE: begin
            if (any_free) spawn_pulse <= 1'b1;
            else          spawn_fail  <= 1'b1;
            retry <= '0;
            state <= ST_GAP;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
    pickup_slot #(.LIFETIME_SEC(LIFETIME_SEC)) u_slot (
      .clk       (clk),
      .resetN    (resetN),
      .one_sec   (one_sec),
      .load      (load_vec[g]),
      .hit       (slot_hit[g]),
      .tile_x_in (cand_x),
      .tile_y_in (cand_y),
      .active    (slot_active[g]),
      .tile_x    (slot_tile_x[g]),
      .tile_y    (slot_tile_y[g])
    );
  end

endmodule
